// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 life array: loader states, tile selectors and
// the cell-to-tile packing rule (also used by the VGA reader).
package life_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RUN} loader_state_t;

   localparam logic [1:0] TILE_NW = 2'd0;
   localparam logic [1:0] TILE_SW = 2'd1;
   localparam logic [1:0] TILE_NE = 2'd2;
   localparam logic [1:0] TILE_SE = 2'd3;

   // Tiles are column-major: the east half of the board lives in tiles 2/3.
   function automatic logic [1:0] cell_to_tile(input logic [2:0] r, input logic [2:0] c);
      return {c[2], r[2]};
   endfunction

   // Each nibble of a tile word is one column of four cells, north in bit 0.
   function automatic logic [3:0] cell_to_bit(input logic [2:0] r, input logic [2:0] c);
      return {c[1:0], r[1:0]};
   endfunction

endpackage

// File: rtl/life_step_timer.sv
// Generation pacing: free-running divider when run_en is high, single-step
// pulses otherwise, and a wrapping count of issued step pulses.
module life_step_timer
   import life_pkg::*;
#(
   parameter int STEP_DIV = 25_000_000,
   parameter int DIV_W    = 25,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             run_en,
   input  logic             single_step,
   input  logic             clear,
   output logic             step,
   output logic [GEN_W-1:0] gen_count
);

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div       <= '0;
         step      <= 1'b0;
         gen_count <= '0;
      end else if (!enable) begin
         div  <= '0;
         step <= 1'b0;
      end else if (run_en) begin
         if (div == DIV_W'(STEP_DIV - 1)) begin
            div       <= '0;
            step      <= 1'b1;
            gen_count <= gen_count + 1'b1;
         end else begin
            div  <= div + 1'b1;
            step <= 1'b0;
         end
      end else begin
         div <= '0;
         // A request landing on the cycle after a pulse is dropped.
         if (single_step && !step) begin
            step      <= 1'b1;
            gen_count <= gen_count + 1'b1;
         end else begin
            step <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/life_loader_8x8.sv
// Host-side loader: collects eight row bytes, writes them as four tile words
// into the life array, then paces generations through life_step_timer.
module life_loader_8x8
   import life_pkg::*;
#(
   parameter int STEP_DIV = 25_000_000,
   parameter int DIV_W    = 25,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             run_en,
   input  logic             single_step,
   output logic [15:0]      vali,
   output logic [1:0]       vali_selector,
   output logic             write_enb,
   output logic             step,
   output logic             busy,
   output logic [GEN_W-1:0] gen_count
);

   loader_state_t      state;
   logic [2:0]         row_cnt;
   logic [1:0]         wr_k;
   logic [7:0][7:0]    rows;
   logic [7:0][7:0]    next_rows;
   logic [3:0][15:0]   tile_w;
   logic               xfer;
   logic               last_row;

   assign in_ready = !reset && (state != WRITE);
   assign xfer     = in_valid && in_ready;
   assign last_row = xfer && (state == COLLECT) && (row_cnt == 3'd7);

   // Pack from the pattern as it will be after this edge, so write cycle 0
   // can issue tile 0 on the same edge that accepts row 7.
   always_comb begin
      next_rows = rows;
      if (xfer) next_rows[row_cnt] = in_data;
   end

   always_comb begin
      tile_w = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            tile_w[cell_to_tile(3'(r), 3'(c))][cell_to_bit(3'(r), 3'(c))] = next_rows[r][c];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         row_cnt       <= '0;
         wr_k          <= '0;
         rows          <= '0;
         vali          <= '0;
         vali_selector <= TILE_NW;
         write_enb     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (xfer) begin
                  rows    <= next_rows;
                  row_cnt <= 3'd1;
                  busy    <= 1'b1;
                  state   <= COLLECT;
               end
            end
            COLLECT: begin
               if (xfer) begin
                  rows    <= next_rows;
                  row_cnt <= row_cnt + 3'd1;
                  if (row_cnt == 3'd7) begin
                     state         <= WRITE;
                     wr_k          <= '0;
                     write_enb     <= 1'b1;
                     vali_selector <= TILE_NW;
                     vali          <= tile_w[0];
                  end
               end
            end
            WRITE: begin
               if (wr_k == 2'd3) begin
                  state         <= RUN;
                  wr_k          <= '0;
                  write_enb     <= 1'b0;
                  vali_selector <= TILE_NW;
                  vali          <= '0;
                  busy          <= 1'b0;
               end else begin
                  wr_k          <= wr_k + 2'd1;
                  vali_selector <= wr_k + 2'd1;
                  vali          <= tile_w[wr_k + 2'd1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   life_step_timer #(
      .STEP_DIV (STEP_DIV),
      .DIV_W    (DIV_W),
      .GEN_W    (GEN_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .enable      ((state == RUN) && !xfer),
      .run_en      (run_en),
      .single_step (single_step),
      .clear       (last_row),
      .step        (step),
      .gen_count   (gen_count)
   );

endmodule

// File: tb/tb_life_loader_8x8.sv
// Self-checking bench for life_loader_8x8: pattern table, corner sequences and
// random traffic, all checked against a frame-level behavioural model.
module tb_life_loader_8x8;
   localparam int STEP_DIV = 4;
   localparam int DIV_W    = 3;
   localparam int GEN_W    = 16;

   logic             clk = 0;
   logic             reset;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             run_en;
   logic             single_step;
   logic [15:0]      vali;
   logic [1:0]       vali_selector;
   logic             write_enb;
   logic             step;
   logic             busy;
   logic [GEN_W-1:0] gen_count;

   life_loader_8x8 #(.STEP_DIV(STEP_DIV), .DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .run_en(run_en), .single_step(single_step),
      .vali(vali), .vali_selector(vali_selector), .write_enb(write_enb),
      .step(step), .busy(busy), .gen_count(gen_count));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   logic [7:0]       m_buf[$];
   logic [63:0]      m_pat;
   int               m_wr;
   bit               m_run;
   int               m_div;
   bit               m_step;
   logic [GEN_W-1:0] m_gen;

   logic [15:0] cap [4];
   int          wr_seen;
   int          steps_seen;

   typedef struct {
      logic [63:0] pat;
      logic [15:0] t [4];
   } vec_t;

   // Cell (r,c) of a tile: r = 4*(t%2) + b%4, c = 4*(t/2) + b/4.
   function automatic logic [15:0] tile_of(input logic [63:0] p, input int t);
      logic [15:0] w;
      for (int b = 0; b < 16; b++)
         w[b] = p[8 * (4 * (t % 2) + b % 4) + 4 * (t / 2) + b / 4];
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit ns = 0;
      if (reset) begin
         m_buf.delete();
         m_wr = -1; m_run = 0; m_div = 0; m_step = 0; m_gen = '0;
      end else begin
         if (m_wr >= 0) begin
            m_wr++;
            if (m_wr == 4) begin m_wr = -1; m_run = 1; end
         end else if (in_valid) begin
            m_buf.push_back(in_data);
            m_run = 0; m_div = 0;
            if (m_buf.size() == 8) begin
               for (int i = 0; i < 8; i++) m_pat[8*i +: 8] = m_buf[i];
               m_buf.delete();
               m_wr = 0; m_gen = '0;
            end
         end else if (m_run) begin
            if (run_en) begin
               m_div++;
               if (m_div == STEP_DIV) begin m_div = 0; ns = 1; end
            end else begin
               m_div = 0;
               ns = single_step && !m_step;
            end
         end
         m_step = ns;
         if (ns) m_gen = m_gen + 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("write_enb", write_enb, m_wr >= 0);
      chk("sel", vali_selector, m_wr >= 0 ? m_wr : 0);
      chk("vali", vali, m_wr >= 0 ? tile_of(m_pat, m_wr) : 16'h0);
      chk("step", step, m_step);
      chk("busy", busy, (m_buf.size() != 0) || (m_wr >= 0));
      chk("gen_count", gen_count, m_gen);
      chk("in_ready", in_ready, !reset && m_wr < 0);
      if (write_enb) begin cap[vali_selector] = vali; wr_seen++; end
      if (step) steps_seen++;
   endtask

   task automatic send_frame(input logic [63:0] p);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_data = p[8*i +: 8];
         tick();
      end
      in_valid = 0;
   endtask

   vec_t vecs [5];
   int   k;
   logic [63:0] fresh;
   logic [4:0]  pulses;

   initial begin
      vecs[0].pat = 64'h0000_0000_0000_0001; vecs[0].t = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
      vecs[1].pat = 64'h0000_8000_0000_0000; vecs[1].t = '{16'h0000, 16'h0000, 16'h0000, 16'h2000};
      vecs[2].pat = 64'h0000_0000_0007_0402; vecs[2].t = '{16'h0654, 16'h0000, 16'h0000, 16'h0000};
      vecs[3].pat = 64'hFFFF_FFFF_FFFF_FFFF; vecs[3].t = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      vecs[4].pat = 64'hAA55_AA55_AA55_AA55; vecs[4].t = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};

      reset = 1; in_valid = 0; in_data = 0; run_en = 0; single_step = 0;
      tick(); tick();
      reset = 0;
      // single_step outside RUN is ignored
      single_step = 1; repeat (3) tick(); single_step = 0;
      chk("idle_no_step", steps_seen, 0);

      foreach (vecs[v]) begin
         wr_seen = 0;
         send_frame(vecs[v].pat);
         repeat (6) tick();
         chk("wr_cycles", wr_seen, 4);
         for (int t = 0; t < 4; t++) chk($sformatf("tile%0d_v%0d", t, v), cap[t], vecs[v].t[t]);
      end

      // free running after glider load
      send_frame(vecs[2].pat);
      repeat (4) tick();
      run_en = 1; steps_seen = 0;
      repeat (12) tick();
      chk("free_run_steps", steps_seen, 3);
      chk("free_run_gen", gen_count, 16'd3);

      // single-step held high: pulses on alternate cycles
      run_en = 0; tick();
      single_step = 1;
      for (int i = 0; i < 5; i++) begin tick(); pulses[i] = step; end
      single_step = 0;
      chk("ss_pattern", pulses, 5'b10101);

      // new byte arriving on the cycle a step is due
      run_en = 1;
      k = 0;
      while (!(m_run && m_div == STEP_DIV - 1) && k < 20) begin tick(); k++; end
      chk("due_found", k < 20, 1'b1);
      in_valid = 1; in_data = 8'h3C; tick();
      chk("due_step_suppressed", step, 1'b0);
      chk("due_busy", busy, 1'b1);
      wr_seen = 0;
      for (int i = 0; i < 7; i++) begin in_data = 8'($urandom); tick(); end
      in_valid = 0;
      repeat (4) tick();
      chk("due_writes", wr_seen, 4);
      chk("due_gen_clear", gen_count, 16'd0);

      // reset after the 5th byte, then a fresh frame
      run_en = 0;
      repeat (5) begin in_valid = 1; in_data = 8'($urandom); tick(); end
      in_valid = 0; reset = 1; tick(); reset = 0;
      steps_seen = 0; wr_seen = 0;
      fresh = {$urandom, $urandom};
      run_en = 1;
      send_frame(fresh);
      chk("no_step_before_write", steps_seen, 0);
      repeat (4) tick();
      chk("fresh_writes", wr_seen, 4);
      for (int t = 0; t < 4; t++) chk($sformatf("fresh_tile%0d", t), cap[t], tile_of(fresh, t));

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 127) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         in_data     = 8'($urandom);
         run_en      = ($urandom_range(0, 1) == 1);
         single_step = ($urandom_range(0, 2) == 0);
         tick();
      end
      reset = 0; in_valid = 0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
